pipe_trace_monitor: RTL and testbench
=====================================

Name: pipe_trace_monitor

Overview:
- Bindable, parametrised pipeline-trace monitor that attaches to a processor stage and samples NUM_CH register-index taps (e.g. decode rd/rs/rt).
- Counts cycles after arming, logs only taps that changed, with a timestamp, into an internal FIFO.
- Signals done after CYCLE_LIMIT cycles; a bench or debug port drains the FIFO.
- Replaces ad-hoc cycle counters and dummy tap interfaces in benches.

Parameters:
- NUM_CH, 3: number of tapped index channels; channel 0 is the destination, 1..NUM_CH-1 are sources.
- IDX_W, 5: width of each register index.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- CYCLE_LIMIT, 25: cycles spent in RUN before DONE; range 1..2^TS_W-1.
- TS_W, 16: timestamp/counter width.
- Derived localparam ENTRY_W = TS_W + NUM_CH + NUM_CH*IDX_W + 1.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: reset; synchronous, active-high.
- arm_i, input, 1: start/restart a capture run.
- tap_i, input, NUM_CH*IDX_W: packed indices; channel k is at [k*IDX_W +: IDX_W].
- tap_valid_i, input, NUM_CH: per-channel valid.
- rd_en_i, input, 1: pop the FIFO head.
- trace_o, output, ENTRY_W: FIFO head entry, first-word-fall-through.
- trace_valid_o, output, 1: FIFO non-empty.
- count_o, output, TS_W: cycles elapsed in the current run.
- done_o, output, 1: high in DONE.
- overflow_o, output, 1: sticky; an entry was dropped.
- hazard_cnt_o, output, TS_W: hazards detected (see Optional Feature).

Behaviour:
- Reset: state=IDLE; FIFO empty; last-captured regs=0; first_f=1. Outputs: trace_valid_o=0, trace_o=0, count_o=0, done_o=0, overflow_o=0, hazard_cnt_o=0.
- FSM IDLE:
  - arm_i -> RUN next cycle; count_o=0, overflow_o=0, first_f=1.
  - The FIFO is not cleared, so prior-run entries stay drainable.
- FSM RUN, each cycle:
  - count_o increments by 1.
  - When count_o == CYCLE_LIMIT-1 at a clock edge -> DONE, and count_o holds CYCLE_LIMIT.
  - arm_i in RUN restarts: count_o=0, first_f=1, overflow_o=0, state stays RUN.
- FSM DONE: done_o=1; count_o holds; arm_i -> RUN as from IDLE.
- Capture (RUN only): push when a valid channel's index differs from its last-captured index, or when first_f=1 and any tap is valid.
  - Entry = {ts=count_o, tap_valid_i, tap_i, hazard_bit}, with hazard_bit in the LSB.
  - On push: last-captured regs for valid channels update, first_f clears.
  - Invalid channels do not update their last-captured reg.
  - Single-cycle latency: an entry pushed at edge N is visible on trace_o after edge N.
- FIFO rules:
  - Pop on rd_en_i && trace_valid_o; pop when empty is ignored.
  - Push while full and no pop: entry dropped, overflow_o=1 (sticky until next arm or reset).
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push lands; the pop is ignored.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full = MSB differs and lower bits are equal.
- Reset mid-run returns everything to reset values on the next edge, overriding arm_i and rd_en_i.

Optional Feature:
- Macro: PIPE_TRACE_HAZARD_EN.
- Defined: a one-cycle-delayed copy of channel 0 is kept (index + valid).
  - In RUN, a hazard occurs when the delayed ch0 is valid, its index != 0, and it equals any valid source channel 1..NUM_CH-1 in the current cycle.
  - A hazard sets the entry's hazard_bit, forces a push that cycle even with no change, and increments hazard_cnt_o (saturating).
  - hazard_cnt_o clears on arm.
- Undefined: hazard_bit=0, hazard_cnt_o tied 0, no extra push.

Decomposition:
- Package pipe_trace_pkg:
  - state enum {IDLE, RUN, DONE};
  - default IDX_W/TS_W constants;
  - function clog2-safe pointer width;
  - field-offset constants for unpacking trace entries in benches.
- One sub-module: trace_fifo (param WIDTH, DEPTH; sync FWFT FIFO with full/empty), instantiated once.

Test Plan:
- Reset then arm_i pulse; taps ch0=5, ch1=3, ch2=4, all valid, constant -> exactly one entry {ts=0, valid=3'b111, taps 5/3/4}; done_o rises after 25 RUN cycles with count_o=25.
- Change ch1 to 7 at ts=4 and ch2 invalid at ts=6 -> entry at ts=4 only; no entry at ts=6.
- DEPTH=4; change a tap every cycle for 6 cycles with no pops -> 4 entries kept (ts 0..3), overflow_o=1; draining yields ts 0,1,2,3 in order.
- FIFO full, push+pop same cycle -> occupancy stays 4, overflow_o stays 0, head advances by one.
- reset_i asserted at ts=10 mid-run -> next cycle state IDLE, trace_valid_o=0, count_o=0.
- PIPE_TRACE_HAZARD_EN: ch0=8 at ts=2, ch1=8 at ts=3 -> entry at ts=3 with hazard_bit=1 and hazard_cnt_o=1; with ch0=0 instead, no hazard.

Source files
------------

// File: rtl/pipe_trace_pkg.sv
// Shared types and helpers for the pipeline-trace monitor and its FIFO.
// Benches use the field-offset helpers to unpack trace entries.
package pipe_trace_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned IDX_W_DEF = 5;
    localparam int unsigned TS_W_DEF  = 16;

    // Entry layout, LSB first: hazard bit, taps, per-channel valids, timestamp.
    localparam int unsigned HZ_LSB  = 0;
    localparam int unsigned TAP_LSB = 1;

    function automatic int unsigned valid_lsb(input int unsigned num_ch, input int unsigned idx_w);
        return TAP_LSB + num_ch * idx_w;
    endfunction

    function automatic int unsigned ts_lsb(input int unsigned num_ch, input int unsigned idx_w);
        return TAP_LSB + num_ch * idx_w + num_ch;
    endfunction

    // Pointer width with an extra wrap bit; never narrower than 2.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 2 : $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero when empty.
module trace_fifo
    import pipe_trace_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_rd   = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_wr) wr_q <= wr_q + 1'b1;
            if (do_rd) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline-trace monitor: timestamps changed register-index taps into a FIFO.
// Define PIPE_TRACE_HAZARD_EN to flag and count RAW hazards against channel 0.
module pipe_trace_monitor
    import pipe_trace_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 3,
    parameter  int unsigned IDX_W       = IDX_W_DEF,
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned CYCLE_LIMIT = 25,
    parameter  int unsigned TS_W        = TS_W_DEF,
    localparam int unsigned ENTRY_W     = TS_W + NUM_CH + NUM_CH * IDX_W + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    arm_i,
    input  logic [NUM_CH*IDX_W-1:0] tap_i,
    input  logic [NUM_CH-1:0]       tap_valid_i,
    input  logic                    rd_en_i,
    output logic [ENTRY_W-1:0]      trace_o,
    output logic                    trace_valid_o,
    output logic [TS_W-1:0]         count_o,
    output logic                    done_o,
    output logic                    overflow_o,
    output logic [TS_W-1:0]         hazard_cnt_o
);

    state_t           state_q, state_n;
    logic [TS_W-1:0]  count_q;
    logic             first_q;
    logic             ovf_q;
    logic [IDX_W-1:0] last_q [NUM_CH];
    logic             changed;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             hazard;
    logic [TS_W-1:0]  hazard_cnt_q;
    logic [ENTRY_W-1:0] entry;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (arm_i) state_n = RUN;
            RUN: begin
                if (arm_i)                                   state_n = RUN;
                else if (count_q == TS_W'(CYCLE_LIMIT - 1)) state_n = DONE;
            end
            DONE:    if (arm_i) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

`ifdef PIPE_TRACE_HAZARD_EN
    logic [IDX_W-1:0] ch0_d_q;
    logic             ch0_vd_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ch0_d_q  <= '0;
            ch0_vd_q <= 1'b0;
        end else begin
            ch0_d_q  <= tap_i[IDX_W-1:0];
            ch0_vd_q <= tap_valid_i[0];
        end
    end

    // Index 0 is the hardwired zero register and never forms a dependency.
    always_comb begin
        hazard = 1'b0;
        if (state_q == RUN && ch0_vd_q && ch0_d_q != '0) begin
            for (int unsigned k = 1; k < NUM_CH; k++) begin
                if (tap_valid_i[k] && tap_i[k*IDX_W +: IDX_W] == ch0_d_q) hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)                          hazard_cnt_q <= '0;
        else if (arm_i)                       hazard_cnt_q <= '0;
        else if (hazard && hazard_cnt_q != '1) hazard_cnt_q <= hazard_cnt_q + 1'b1;
    end
`else
    assign hazard       = 1'b0;
    assign hazard_cnt_q = '0;
`endif

    always_comb begin
        changed = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (tap_valid_i[k] && tap_i[k*IDX_W +: IDX_W] != last_q[k]) changed = 1'b1;
        end
        push = (state_q == RUN) && (changed || (first_q && |tap_valid_i) || hazard);
    end

    assign pop   = rd_en_i && !fifo_empty;
    assign drop  = push && fifo_full && !pop;
    assign entry = {count_q, tap_valid_i, tap_i, hazard};

    // Last-captured indices track every push attempt, even one dropped at full.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) last_q[k] <= '0;
        end else begin
            if (arm_i) begin
                count_q <= '0;
                first_q <= 1'b1;
                ovf_q   <= 1'b0;
            end else begin
                if (state_q == RUN) count_q <= count_q + 1'b1;
                if (push)           first_q <= 1'b0;
                if (drop)           ovf_q   <= 1'b1;
            end
            if (push) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (tap_valid_i[k]) last_q[k] <= tap_i[k*IDX_W +: IDX_W];
                end
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (push),
        .wr_data_i (entry),
        .rd_en_i   (rd_en_i),
        .rd_data_o (trace_o),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign trace_valid_o = !fifo_empty;
    assign count_o       = count_q;
    assign done_o        = (state_q == DONE);
    assign overflow_o    = ovf_q;
    assign hazard_cnt_o  = hazard_cnt_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Scoreboard bench for pipe_trace_monitor: directed scenarios plus random taps,
// checked against a behavioural model of the capture and FIFO rules.
module tb_pipe_trace_monitor;
    import pipe_trace_pkg::*;

    localparam int unsigned NCH   = 3;
    localparam int unsigned IW    = 5;
    localparam int unsigned DEP   = 4;
    localparam int unsigned LIM   = 25;
    localparam int unsigned TW    = 16;
    localparam int unsigned EW    = TW + NCH + NCH * IW + 1;
`ifdef PIPE_TRACE_HAZARD_EN
    localparam int unsigned HZ_ON = 1;
`else
    localparam int unsigned HZ_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              arm_i = 1'b0;
    logic [NCH*IW-1:0] tap_i = '0;
    logic [NCH-1:0]    tap_valid_i = '0;
    logic              rd_en_i = 1'b0;
    logic [EW-1:0]     trace_o;
    logic              trace_valid_o;
    logic [TW-1:0]     count_o;
    logic              done_o;
    logic              overflow_o;
    logic [TW-1:0]     hazard_cnt_o;

    pipe_trace_monitor #(
        .NUM_CH      (NCH),
        .IDX_W       (IW),
        .DEPTH       (DEP),
        .CYCLE_LIMIT (LIM),
        .TS_W        (TW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .arm_i         (arm_i),
        .tap_i         (tap_i),
        .tap_valid_i   (tap_valid_i),
        .rd_en_i       (rd_en_i),
        .trace_o       (trace_o),
        .trace_valid_o (trace_valid_o),
        .count_o       (count_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o),
        .hazard_cnt_o  (hazard_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 running, 2 finished.
    int          m_phase = 0;
    int unsigned m_count = 0;
    bit          m_first = 1'b1;
    bit          m_ovf   = 1'b0;
    int unsigned m_hcnt  = 0;
    int unsigned m_last [NCH];
    int unsigned m_d0    = 0;
    bit          m_d0v   = 1'b0;
    logic [EW-1:0] exp_q [$];

    logic [NCH*IW-1:0] cur_t = '0;
    logic [NCH-1:0]    cur_v = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*IW-1:0] taps(input int unsigned a, input int unsigned b, input int unsigned c);
        return {IW'(c), IW'(b), IW'(a)};
    endfunction

    function automatic logic [TW-1:0] ts_of(input logic [EW-1:0] e);
        logic [EW-1:0] s;
        s = e >> ts_lsb(NCH, IW);
        return s[TW-1:0];
    endfunction

    // Advances the model across the next clock edge for the given inputs.
    task automatic model(input bit a, input logic [NCH*IW-1:0] t, input logic [NCH-1:0] v,
                         input bit r, input bit rs);
        int unsigned idx [NCH];
        bit pop, chg, hz;
        logic [EW-1:0] e;
        for (int k = 0; k < NCH; k++) idx[k] = (int'(t) >> (IW * k)) & ((1 << IW) - 1);
        if (rs) begin
            m_phase = 0; m_count = 0; m_first = 1'b1; m_ovf = 1'b0; m_hcnt = 0;
            for (int k = 0; k < NCH; k++) m_last[k] = 0;
            m_d0 = 0; m_d0v = 1'b0;
            exp_q.delete();
            return;
        end
        pop = r && (exp_q.size() > 0);
        if (m_phase == 1) begin
            chg = 1'b0;
            hz  = 1'b0;
            for (int k = 0; k < NCH; k++) if (v[k] && idx[k] != m_last[k]) chg = 1'b1;
            if (HZ_ON != 0 && m_d0v && m_d0 != 0)
                for (int k = 1; k < NCH; k++) if (v[k] && idx[k] == m_d0) hz = 1'b1;
            if (chg || (m_first && v != '0) || hz) begin
                e = {TW'(m_count), v, t, hz};
                if (exp_q.size() < DEP || pop) exp_q.push_back(e);
                else m_ovf = 1'b1;
                for (int k = 0; k < NCH; k++) if (v[k]) m_last[k] = idx[k];
                m_first = 1'b0;
            end
            if (hz && m_hcnt < (1 << TW) - 1) m_hcnt++;
            if (!a) begin
                if (m_count == LIM - 1) m_phase = 2;
                m_count++;
            end
        end
        if (a) begin
            m_phase = 1; m_count = 0; m_first = 1'b1; m_ovf = 1'b0; m_hcnt = 0;
        end
        m_d0  = idx[0];
        m_d0v = v[0];
    endtask

    task automatic step(input bit a, input logic [NCH*IW-1:0] t, input logic [NCH-1:0] v,
                        input bit r, input bit rs);
        arm_i = a; tap_i = t; tap_valid_i = v; rd_en_i = r; reset_i = rs;
        cur_t = t; cur_v = v;
        model(a, t, v, r, rs);
        @(posedge clk);
        #1;
        chk("count", 64'(count_o), 64'(m_count));
        chk("done", 64'(done_o), 64'(m_phase == 2));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("hazard_cnt", 64'(hazard_cnt_o), 64'(m_hcnt));
        chk("trace_valid", 64'(trace_valid_o), 64'(exp_q.size() != 0));
    endtask

    task automatic run_to_done();
        for (int i = 0; i < 40; i++) begin
            if (done_o) break;
            step(1'b0, cur_t, cur_v, 1'b0, 1'b0);
        end
        chk("run_done_timeout", 64'(done_o), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < DEP + 4; i++) begin
            if (!trace_valid_o) break;
            step(1'b0, cur_t, cur_v, 1'b1, 1'b0);
        end
        chk("drained", 64'(trace_valid_o), 64'd0);
    endtask

    // Monitor: every accepted pop must present the scoreboard head.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset_i && rd_en_i && trace_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected actual=%0h required=none at %0t", trace_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (trace_o !== e) begin
                        errors++;
                        $display("FAIL pop_entry actual=%0h (ts %0d) required=%0h (ts %0d) at %0t",
                                 trace_o, ts_of(trace_o), e, ts_of(e), $time);
                    end
                end
            end
        end
    end

    initial begin
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        chk("reset_trace", 64'(trace_o), 64'd0);

        // Constant taps, ch1 change at ts 4, ch2 invalid from ts 6.
        step(1'b1, taps(5, 3, 4), 3'b111, 1'b0, 1'b0);
        for (int ts = 0; ts < LIM; ts++)
            step(1'b0, taps(5, (ts >= 4) ? 7 : 3, 4), (ts >= 6) ? 3'b011 : 3'b111, 1'b0, 1'b0);
        chk("done_at_limit", 64'(done_o), 64'd1);
        chk("count_at_limit", 64'(count_o), 64'(LIM));
        chk("first_entry_ts", 64'(ts_of(trace_o)), 64'd0);
        chk("first_entry_valid", 64'((trace_o >> valid_lsb(NCH, IW)) & 7), 64'd7);
        drain();

        // Overflow: six changes with no pops.
        step(1'b1, taps(10, 0, 0), 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, taps(10 + i, 0, 0), 3'b001, 1'b0, 1'b0);
        chk("overflow_set", 64'(overflow_o), 64'd1);
        run_to_done();
        drain();

        // Full FIFO with simultaneous push and pop.
        step(1'b1, taps(20, 0, 0), 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, taps(20 + i, 0, 0), 3'b001, 1'b0, 1'b0);
        step(1'b0, taps(24, 0, 0), 3'b001, 1'b1, 1'b0);
        chk("full_pushpop_ovf", 64'(overflow_o), 64'd0);
        chk("full_pushpop_head", 64'(ts_of(trace_o)), 64'd1);
        run_to_done();
        drain();

        // Reset mid-run overrides arm and pop.
        step(1'b1, taps(1, 1, 1), 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, taps(i / 3 + 1, 2, 2), 3'b111, 1'b0, 1'b0);
        step(1'b1, taps(9, 9, 9), 3'b111, 1'b1, 1'b1);
        chk("midrun_reset_count", 64'(count_o), 64'd0);
        chk("midrun_reset_valid", 64'(trace_valid_o), 64'd0);
        chk("midrun_reset_done", 64'(done_o), 64'd0);
        step(1'b0, taps(9, 9, 9), 3'b111, 1'b0, 1'b0);

        // Read-after-write against ch0, then the same with index 0.
        step(1'b1, taps(1, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(1, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(1, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(8, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(8, 8, 3), 3'b111, 1'b0, 1'b0);
        chk("hazard_directed", 64'(hazard_cnt_o), 64'(HZ_ON));
        run_to_done();
        drain();
        step(1'b1, taps(1, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(1, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(1, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(0, 2, 3), 3'b111, 1'b0, 1'b0);
        step(1'b0, taps(0, 0, 3), 3'b111, 1'b0, 1'b0);
        chk("hazard_zero_idx", 64'(hazard_cnt_o), 64'd0);
        run_to_done();
        drain();

        // Random taps from a small index pool, random pops and occasional re-arm.
        step(1'b1, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++)
            step(($urandom % 25) == 0,
                 taps($urandom % 4, $urandom % 4, $urandom % 4),
                 NCH'($urandom), $urandom % 2 == 0, 1'b0);
        run_to_done();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
